arb_sel_2x1: RTL and testbench

ARB_SEL_2X1 -- requirements
Module: arb_sel_2x1

---
 rtl/arb_sel_2x1.sv | 132 +++++++++++++
 tb/tb_arb_sel_2x1.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_sel_2x1.sv
// Two-source round-robin arbiter driving the select of a downstream 2:1 mux.
// Optional grant-hold timeout is compiled in with `define ARB_TIMEOUT_EN (limit = MAX_HOLD cycles).
module arb_sel_2x1 #(
    parameter int MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1,
    output logic s,
    output logic busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
            $error("arb_sel_2x1: MAX_HOLD must lie in 2..256");
        end
    endgenerate

    logic [1:0] state_q, state_d;
    logic       lp_q, lp_d;
    logic       s_q, s_d;
    logic       grant0_q, grant0_d;
    logic       grant1_q, grant1_d;
    logic       busy_q, busy_d;
    logic       timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (state_q != IDLE) && (cnt_q == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = lp_q ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                // Timeout hands over only when the other side is actually waiting.
                if (timeout && req1) begin
                    state_d = GNT1;
                end else if (!req0) begin
                    state_d = req1 ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (timeout && req0) begin
                    state_d = GNT0;
                end else if (!req1) begin
                    state_d = req0 ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state value so they switch on the same edge as state.
    always_comb begin
        lp_d     = lp_q;
        s_d      = s_q;
        grant0_d = (state_d == GNT0);
        grant1_d = (state_d == GNT1);
        busy_d   = grant0_d | grant1_d;
        if (state_d == GNT0 && state_q != GNT0) begin
            lp_d = 1'b0;
            s_d  = 1'b0;
        end else if (state_d == GNT1 && state_q != GNT1) begin
            lp_d = 1'b1;
            s_d  = 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        cnt_d = '0;
        if (state_d != IDLE && state_d == state_q) begin
            cnt_d = timeout ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lp_q     <= 1'b1;
            s_q      <= 1'b0;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lp_q     <= lp_d;
            s_q      <= s_d;
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            busy_q   <= busy_d;
        end
    end

    assign grant0 = grant0_q;
    assign grant1 = grant1_q;
    assign s      = s_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_arb_sel_2x1.sv
// Directed bench for arb_sel_2x1; timeout scenarios run when ARB_TIMEOUT_EN is defined (MAX_HOLD=4).
module tb_arb_sel_2x1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic grant0, grant1, s, busy;

    int vectors = 0;
    int miscompares = 0;

    // packed observation {grant0, grant1, s, busy}
    logic [3:0] obs;
    assign obs = {grant0, grant1, s, busy};

    localparam logic [3:0] O_IDLE_S0 = 4'b0000;
    localparam logic [3:0] O_IDLE_S1 = 4'b0010;
    localparam logic [3:0] O_G0      = 4'b1001;
    localparam logic [3:0] O_G1      = 4'b0111;

    arb_sel_2x1 #(.MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .grant0 (grant0),
        .grant1 (grant1),
        .s      (s),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        vectors++;
        if (obs !== O_IDLE_S0) begin
            miscompares++;
            $display("FAIL reset_hold got=%b want=%b", obs, O_IDLE_S0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_req();
        do_reset();
        step();
        step();
        req0 = 1'b1;
        #1;
        vectors++;
        if (obs !== O_IDLE_S0) begin
            miscompares++;
            $display("FAIL single_no_comb got=%b want=%b", obs, O_IDLE_S0);
        end
        step();
        vectors++;
        if (obs !== O_G0) begin
            miscompares++;
            $display("FAIL single_grant0 got=%b want=%b", obs, O_G0);
        end
        req0 = 1'b0;
        step();
        vectors++;
        if (obs !== O_IDLE_S0) begin
            miscompares++;
            $display("FAIL single_release got=%b want=%b", obs, O_IDLE_S0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        vectors++;
        if (obs !== O_G0) begin
            miscompares++;
            $display("FAIL simul_first got=%b want=%b", obs, O_G0);
        end
        step();
        step();
        req0 = 1'b0;
        step();
        vectors++;
        if (obs !== O_G1) begin
            miscompares++;
            $display("FAIL simul_b2b got=%b want=%b", obs, O_G1);
        end
        req1 = 1'b0;
        step();
        vectors++;
        if (obs !== O_IDLE_S1) begin
            miscompares++;
            $display("FAIL simul_idle_s_hold got=%b want=%b", obs, O_IDLE_S1);
        end
    endtask

    // Entered from IDLE with lp=1 (left by test_simultaneous), so GNT0 wins first.
    task automatic test_alternate();
        logic exp_g;
        logic [3:0] want;
        exp_g = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                want = exp_g ? O_G1 : O_G0;
                vectors++;
                if (obs !== want) begin
                    miscompares++;
                    $display("FAIL alternate k=%0d c=%0d got=%b want=%b", k, c, obs, want);
                end
                if (c < 3) step();
            end
            if (k < 3) begin
                if (exp_g) req1 = 1'b0; else req0 = 1'b0;
                step();
                req0 = 1'b1;
                req1 = 1'b1;
                exp_g = ~exp_g;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        vectors++;
        if (obs !== O_IDLE_S1) begin
            miscompares++;
            $display("FAIL alternate_idle got=%b want=%b", obs, O_IDLE_S1);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req1 = 1'b1;
        step();
        vectors++;
        if (obs !== O_G1) begin
            miscompares++;
            $display("FAIL midrst_setup got=%b want=%b", obs, O_G1);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== O_IDLE_S0) begin
            miscompares++;
            $display("FAIL midrst_async got=%b want=%b", obs, O_IDLE_S0);
        end
        req1 = 1'b0;
        #2 rst_n = 1'b1;
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout_switch();
        do_reset();
        req0 = 1'b1;
        step();
        req1 = 1'b1;
        for (int c = 1; c < 4; c++) begin
            step();
            vectors++;
            if (obs !== O_G0) begin
                miscompares++;
                $display("FAIL timeout_hold0 c=%0d got=%b want=%b", c, obs, O_G0);
            end
        end
        step();
        vectors++;
        if (obs !== O_G1) begin
            miscompares++;
            $display("FAIL timeout_switch1 got=%b want=%b", obs, O_G1);
        end
        for (int c = 0; c < 3; c++) step();
        step();
        vectors++;
        if (obs !== O_G0) begin
            miscompares++;
            $display("FAIL timeout_switch0 got=%b want=%b", obs, O_G0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
    endtask

    task automatic test_timeout_alone();
        do_reset();
        req0 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            vectors++;
            if (obs !== O_G0) begin
                miscompares++;
                $display("FAIL timeout_alone c=%0d got=%b want=%b", c, obs, O_G0);
            end
        end
        // Counter wrapped to MAX_HOLD-1 on this cycle, so a new req1 switches immediately.
        req1 = 1'b1;
        step();
        vectors++;
        if (obs !== O_G1) begin
            miscompares++;
            $display("FAIL timeout_wrap got=%b want=%b", obs, O_G1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        req0 = 1'b1;
        step();
        req1 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            vectors++;
            if (obs !== O_G0) begin
                miscompares++;
                $display("FAIL no_timeout c=%0d got=%b want=%b", c, obs, O_G0);
            end
        end
        req0 = 1'b0;
        step();
        vectors++;
        if (obs !== O_G1) begin
            miscompares++;
            $display("FAIL no_timeout_handover got=%b want=%b", obs, O_G1);
        end
        req1 = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single_req();
        test_simultaneous();
        test_alternate();
        test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
        test_timeout_switch();
        test_timeout_alone();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
